// File: rtl/board_pkg.sv
// Shared definitions for the board controller slice.
// Holds the board geometry, the controller state encoding and the cell-index helper
// used to map a (row, col) cursor position onto a bit of the 36-bit board buses.
package board_pkg;

    localparam int unsigned ROWS    = 6;
    localparam int unsigned COLS    = 6;
    localparam int unsigned N_CELLS = ROWS * COLS;
    localparam int unsigned PAIRS   = N_CELLS / 2;
    localparam int unsigned TIMER_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StOne,
        StWait,
        StHold,
        StWon
    } state_e;

    // Linear cell index k = COLS*row + col. Six bits cover out-of-range inputs (max 7*6+7),
    // so callers can range-check separately without the index wrapping.
    function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return {3'b000, row} * 6'(COLS) + {3'b000, col};
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the match watchdog and the mismatch display hold.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous return to zero (new game)
//   load       load value into the counter (wins over tick)
//   value      count to load
//   tick       decrement by one (saturates at zero)
//   zero       counter is zero, or reaches zero on this tick
module cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             tick,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = value;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag the expiring tick itself so the owner can act on the same edge the count hits 0.
    assign zero = (count_q == '0) || (tick && (count_q == WIDTH'(1)));

endmodule

// File: rtl/board_ctrl.sv
// Live 6x6 board state for the memory game.
// Turns cursor pick pulses into a selection of at most two cards, presents the selection
// and the removed cells to the matcher, and applies the matcher's verdict: matched pairs are
// removed, mismatched pairs stay shown for FAIL_HOLD cycles, a missing verdict is aborted by
// a watchdog after MATCH_TO cycles. Tracks remaining pairs and flags the win.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   new_game            sync pulse, restores the reset state (priority over everything)
//   pick, pick_row/col  one-cycle select pulse at (row, col)
//   ms, mf              matcher verdict pulses: match / fail (ms wins if both)
//   sel_bus             selected cells, bit k = 6*row+col
//   hidden_bus          removed cells
//   pairs_left          pairs still on the board
//   busy                waiting for verdict or showing a mismatch
//   bad_pick            one-cycle pulse, pick rejected
//   timeout             one-cycle pulse, watchdog aborted a wait
//   win                 level, all pairs cleared
module board_ctrl
    import board_pkg::*;
#(
    parameter int unsigned FAIL_HOLD = 50,
    parameter int unsigned MATCH_TO  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        pick,
    input  logic [2:0]  pick_row,
    input  logic [2:0]  pick_col,
    input  logic        ms,
    input  logic        mf,
    output logic [35:0] sel_bus,
    output logic [35:0] hidden_bus,
    output logic [4:0]  pairs_left,
    output logic        busy,
    output logic        bad_pick,
    output logic        timeout,
    output logic        win
);

    localparam logic [TIMER_W-1:0] MatchToVal  = TIMER_W'(MATCH_TO);
    localparam logic [TIMER_W-1:0] FailHoldVal = TIMER_W'(FAIL_HOLD);
    localparam logic [4:0]         PairsInit   = 5'(PAIRS);

    state_e               state_q, state_d;
    logic [N_CELLS-1:0]   sel_q, sel_d;
    logic [N_CELLS-1:0]   hidden_q, hidden_d;
    logic [4:0]           pairs_q, pairs_d;
    logic                 busy_q, busy_d;
    logic                 win_q, win_d;
    logic                 bad_pick_q, bad_pick_d;
    logic                 timeout_q, timeout_d;

    // Decoded pick
    logic [5:0]           pick_idx;
    logic                 pick_in_range;
    logic [N_CELLS-1:0]   pick_mask;
    logic                 pick_ok;
    logic                 pick_on_sel;

    // Actions decided by the FSM, applied by the datapath
    logic                 do_set;
    logic                 do_unsel;
    logic                 do_match;
    logic                 do_drop;

    // Shared timer
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_tick;
    logic                 timer_zero;

    assign pick_idx      = cell_idx(pick_row, pick_col);
    assign pick_in_range = (pick_row < 3'(ROWS)) && (pick_col < 3'(COLS));
    // Out-of-range picks get an empty mask so they never touch a board bit.
    assign pick_mask     = pick_in_range ? ({{(N_CELLS-1){1'b0}}, 1'b1} << pick_idx) : '0;
    assign pick_ok       = pick_in_range && ((pick_mask & hidden_q) == '0);
    assign pick_on_sel   = (pick_mask & sel_q) != '0;

    assign timer_tick    = ((state_q == StWait) || (state_q == StHold)) && !timer_load;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (new_game),
        .load  (timer_load),
        .value (timer_val),
        .tick  (timer_tick),
        .zero  (timer_zero)
    );

    // State register and all datapath/output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            hidden_q   <= '0;
            pairs_q    <= PairsInit;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            bad_pick_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            hidden_q   <= hidden_d;
            pairs_q    <= pairs_d;
            busy_q     <= busy_d;
            win_q      <= win_d;
            bad_pick_q <= bad_pick_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and action decode
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = '0;
        do_set     = 1'b0;
        do_unsel   = 1'b0;
        do_match   = 1'b0;
        do_drop    = 1'b0;
        bad_pick_d = 1'b0;
        timeout_d  = 1'b0;

        if (new_game) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick) begin
                        if (pick_ok) begin
                            do_set  = 1'b1;
                            state_d = StOne;
                        end else begin
                            bad_pick_d = 1'b1;
                        end
                    end
                end
                StOne: begin
                    if (pick) begin
                        if (!pick_ok) begin
                            bad_pick_d = 1'b1;
                        end else if (pick_on_sel) begin
                            do_unsel = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            do_set     = 1'b1;
                            state_d    = StWait;
                            timer_load = 1'b1;
                            timer_val  = MatchToVal;
                        end
                    end
                end
                StWait: begin
                    bad_pick_d = pick;
                    if (ms) begin
                        do_match = 1'b1;
                        // Last pair (or an already empty count) ends the game.
                        state_d  = (pairs_q <= 5'd1) ? StWon : StIdle;
                    end else if (mf) begin
                        state_d    = StHold;
                        timer_load = 1'b1;
                        timer_val  = FailHoldVal;
                    end else if (timer_zero) begin
                        do_drop   = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                StHold: begin
                    bad_pick_d = pick;
                    if (timer_zero) begin
                        do_drop = 1'b1;
                        state_d = StIdle;
                    end
                end
                StWon: begin
                    bad_pick_d = pick;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Board datapath
    always_comb begin
        sel_d    = sel_q;
        hidden_d = hidden_q;
        pairs_d  = pairs_q;
        if (new_game) begin
            sel_d    = '0;
            hidden_d = '0;
            pairs_d  = PairsInit;
        end else begin
            if (do_set) begin
                sel_d = sel_q | pick_mask;
            end
            if (do_unsel) begin
                sel_d = sel_q & ~pick_mask;
            end
            if (do_match) begin
                hidden_d = hidden_q | sel_q;
                sel_d    = '0;
                if (pairs_q != 5'd0) begin
                    pairs_d = pairs_q - 5'd1;
                end
            end
            if (do_drop) begin
                sel_d = '0;
            end
        end
    end

    // Outputs: status levels precomputed from the next state so every port comes from a flop
    always_comb begin
        busy_d     = (state_d == StWait) || (state_d == StHold);
        win_d      = (state_d == StWon);
        sel_bus    = sel_q;
        hidden_bus = hidden_q;
        pairs_left = pairs_q;
        busy       = busy_q;
        win        = win_q;
        bad_pick   = bad_pick_q;
        timeout    = timeout_q;
    end

endmodule
